// File: rtl/proton_mem_pkg.sv
// Shared types and constants for the PROTON memory responder.
// Used by both the responder top and its word array.
package proton_mem_pkg;

    localparam int DATA_LENGTH_DEF   = 32;
    localparam int ADDRESS_LINES_DEF = 10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    // A zero-wait build still needs a one-bit counter so the port widths stay legal.
    function automatic int cnt_width(input int wait_states);
        int w;
        w = $clog2(wait_states + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/proton_mem_array.sv
// Single-port word array with write enable and registered read.
// With PROTON_MEM_PARITY_EN defined, one parity bit is stored alongside each word.
module proton_mem_array
    import proton_mem_pkg::*;
#(
    parameter int DATA_LENGTH   = DATA_LENGTH_DEF,
    parameter int ADDRESS_LINES = ADDRESS_LINES_DEF
) (
    input  logic                     CLK,
    input  logic                     en,
    input  logic                     we,
    input  logic [ADDRESS_LINES-1:0] addr,
    input  logic [DATA_LENGTH-1:0]   wdata,
`ifdef PROTON_MEM_PARITY_EN
    input  logic                     wpar,
    output logic                     rpar,
`endif
    output logic [DATA_LENGTH-1:0]   rdata
);

    localparam int DEPTH = 2 ** ADDRESS_LINES;

    logic [DATA_LENGTH-1:0] mem [0:DEPTH-1];
    logic [DATA_LENGTH-1:0] rdata_q;

    // The read register only moves on a read, so it holds through backpressure.
    always_ff @(posedge CLK) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

`ifdef PROTON_MEM_PARITY_EN
    logic par_mem [0:DEPTH-1];
    logic rpar_q;

    always_ff @(posedge CLK) begin
        if (en) begin
            if (we) begin
                par_mem[addr] <= wpar;
            end else begin
                rpar_q <= par_mem[addr];
            end
        end
    end

    assign rpar = rpar_q;
`endif

endmodule

// File: rtl/proton_mem_responder.sv
// Word-addressed memory responder: valid/ready request in, wait states, valid/ready completion out.
// Optional per-word even parity is enabled by defining PROTON_MEM_PARITY_EN (adds PAR_INJECT).
module proton_mem_responder
    import proton_mem_pkg::*;
#(
    parameter int DATA_LENGTH   = DATA_LENGTH_DEF,
    parameter int ADDRESS_LINES = ADDRESS_LINES_DEF,
    parameter int WAIT_STATES   = 1
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   REQ_VALID,
    output logic                   REQ_READY,
    input  logic                   REQ_WE,
    input  logic [DATA_LENGTH-1:0] REQ_ADDR,
    input  logic [DATA_LENGTH-1:0] REQ_WDATA,
`ifdef PROTON_MEM_PARITY_EN
    input  logic                   PAR_INJECT,
`endif
    output logic                   RSP_VALID,
    input  logic                   RSP_READY,
    output logic [DATA_LENGTH-1:0] RSP_RDATA,
    output logic                   RSP_ERR
);

    localparam int             CW       = cnt_width(WAIT_STATES);
    localparam logic [CW-1:0]  CNT_INIT = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [DATA_LENGTH-1:0] addr_q, addr_d;
    logic [DATA_LENGTH-1:0] wdata_q, wdata_d;
    logic                   req_ready_q, req_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_err_q, rsp_err_d;
    logic                   rd_ok_q, rd_ok_d;

    logic                   accept;
    logic                   commit;
    logic                   c_we;
    logic [DATA_LENGTH-1:0] c_addr;
    logic [DATA_LENGTH-1:0] c_wdata;
    logic                   c_oor;
    logic                   mem_en;
    logic [DATA_LENGTH-1:0] mem_rdata;

    assign accept = (state_q == IDLE) && REQ_VALID && req_ready_q;

    // With zero wait states the commit happens on the accept edge, so it uses the live request.
    assign c_we    = (state_q == IDLE) ? REQ_WE    : we_q;
    assign c_addr  = (state_q == IDLE) ? REQ_ADDR  : addr_q;
    assign c_wdata = (state_q == IDLE) ? REQ_WDATA : wdata_q;

    generate
        if (ADDRESS_LINES < DATA_LENGTH) begin : g_range
            assign c_oor = |c_addr[DATA_LENGTH-1:ADDRESS_LINES];
        end else begin : g_no_range
            assign c_oor = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rd_ok_d     = rd_ok_q;
        commit      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d        = REQ_WE;
                    addr_d      = REQ_ADDR;
                    wdata_d     = REQ_WDATA;
                    req_ready_d = 1'b0;
                    if (WAIT_STATES == 0) begin
                        commit  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rd_ok_d     = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rd_ok_d     = 1'b0;
            end
        endcase

        if (commit) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = c_oor;
            rd_ok_d     = !c_we && !c_oor;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_ok_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rd_ok_q     <= rd_ok_d;
        end
    end

    // Out-of-range requests never touch the array.
    assign mem_en = commit && !c_oor;

    assign REQ_READY = req_ready_q;
    assign RSP_VALID = rsp_valid_q;

`ifdef PROTON_MEM_PARITY_EN
    logic par_inj_q, par_inj_d;
    logic c_inj;
    logic mem_rpar;
    logic par_fail;

    assign par_inj_d = accept ? PAR_INJECT : par_inj_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            par_inj_q <= 1'b0;
        end else begin
            par_inj_q <= par_inj_d;
        end
    end

    assign c_inj    = (state_q == IDLE) ? PAR_INJECT : par_inj_q;
    assign par_fail = rd_ok_q && ((^mem_rdata) != mem_rpar);
    assign RSP_ERR   = rsp_err_q | par_fail;
    assign RSP_RDATA = (rd_ok_q && !par_fail) ? mem_rdata : '0;
`else
    assign RSP_ERR   = rsp_err_q;
    assign RSP_RDATA = rd_ok_q ? mem_rdata : '0;
`endif

    proton_mem_array #(
        .DATA_LENGTH   (DATA_LENGTH),
        .ADDRESS_LINES (ADDRESS_LINES)
    ) u_array (
        .CLK   (CLK),
        .en    (mem_en),
        .we    (c_we),
        .addr  (c_addr[ADDRESS_LINES-1:0]),
        .wdata (c_wdata),
`ifdef PROTON_MEM_PARITY_EN
        .wpar  ((^c_wdata) ^ c_inj),
        .rpar  (mem_rpar),
`endif
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_proton_mem_responder.sv
// Scoreboard bench for proton_mem_responder: one instance with one wait state, one with none.
// Parity checks are compiled in when PROTON_MEM_PARITY_EN is defined.
module tb_proton_mem_responder;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   cyc;
    exp_t sb[$];

    // Instance with WAIT_STATES=1
    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    // Instance with WAIT_STATES=0, RSP_READY tied high
    logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
`ifdef PROTON_MEM_PARITY_EN
    logic        par_inject, z_par_inject;
`endif

    proton_mem_responder #(.DATA_LENGTH(32), .ADDRESS_LINES(10), .WAIT_STATES(1)) u_dut (
        .CLK(clk), .RST_N(rst_n),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
        .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
`ifdef PROTON_MEM_PARITY_EN
        .PAR_INJECT(par_inject),
`endif
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err)
    );

    proton_mem_responder #(.DATA_LENGTH(32), .ADDRESS_LINES(10), .WAIT_STATES(0)) u_dut0 (
        .CLK(clk), .RST_N(rst_n),
        .REQ_VALID(z_req_valid), .REQ_READY(z_req_ready), .REQ_WE(z_req_we),
        .REQ_ADDR(z_req_addr), .REQ_WDATA(z_req_wdata),
`ifdef PROTON_MEM_PARITY_EN
        .PAR_INJECT(z_par_inject),
`endif
        .RSP_VALID(z_rsp_valid), .RSP_READY(z_rsp_ready), .RSP_RDATA(z_rsp_rdata), .RSP_ERR(z_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send(input bit sel, input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic inj, output bit acc);
        acc = 1'b0;
        if (sel) begin
            z_req_we = we; z_req_addr = a; z_req_wdata = d; z_req_valid = 1'b1;
        end else begin
            req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
        end
`ifdef PROTON_MEM_PARITY_EN
        if (sel) z_par_inject = inj; else par_inject = inj;
`else
        if (inj) acc = 1'b0;
`endif
        for (int i = 0; i < 20 && !acc; i++) begin
            if (sel ? z_req_ready : req_ready) acc = 1'b1;
            @(negedge clk);
        end
        if (sel) z_req_valid = 1'b0; else req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input bit sel, output bit got, output int lat);
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            if (sel ? z_rsp_valid : rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    // Full transaction on the one-wait-state instance, including the response handshake.
    task automatic txn1(input logic we, input logic [31:0] a, input logic [31:0] d, input logic inj,
                        output bit ok, output int lat, output logic [31:0] rd, output logic er);
        bit acc, got;
        send(1'b0, we, a, d, inj, acc);
        wait_rsp(1'b0, got, lat);
        rd = rsp_rdata;
        er = rsp_err;
        ok = acc && got;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        bit ok; int lat; logic [31:0] rd; logic er; exp_t e; bit acc;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: ready=%b valid=%b rdata=%h err=%b, required 1 0 00000000 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        sb.push_back('{1'b0, 32'h0});
        txn1(1'b1, 32'd5, 32'h11111111, 1'b0, ok, lat, rd, er);
        e = sb.pop_front();
        checks++;
        if (ok !== 1'b1 || rd !== e.rdata || er !== e.err) begin
            errors++;
            $display("FAIL reset_seed_write: ok=%b rdata=%h err=%b, required 1 %h %b", ok, rd, er, e.rdata, e.err);
        end
        // Write dropped by a reset in the middle of WAIT
        send(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0, acc);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (acc !== 1'b1 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait: acc=%b ready=%b valid=%b rdata=%h err=%b, required 1 1 0 00000000 0",
                     acc, req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sb.push_back('{1'b0, 32'h11111111});
        txn1(1'b0, 32'd5, 32'h0, 1'b0, ok, lat, rd, er);
        e = sb.pop_front();
        checks++;
        if (ok !== 1'b1 || rd !== e.rdata || er !== e.err) begin
            errors++;
            $display("FAIL reset_addr5_kept: ok=%b rdata=%h err=%b, required 1 %h %b", ok, rd, er, e.rdata, e.err);
        end
        $display("txn reset: addr5 read back %h", rd);
    endtask

    task automatic test_write_read();
        bit ok; int lat; logic [31:0] rd; logic er; exp_t e;
        sb.push_back('{1'b0, 32'h0});
        txn1(1'b1, 32'd3, 32'h12345678, 1'b0, ok, lat, rd, er);
        e = sb.pop_front();
        checks++;
        if (ok !== 1'b1 || rd !== e.rdata || er !== e.err || lat != 1) begin
            errors++;
            $display("FAIL write_addr3: ok=%b rdata=%h err=%b lat=%0d, required 1 %h %b 1", ok, rd, er, lat, e.rdata, e.err);
        end
        $display("txn write addr=3 data=12345678 err=%b", er);
        sb.push_back('{1'b0, 32'h12345678});
        txn1(1'b0, 32'd3, 32'h0, 1'b0, ok, lat, rd, er);
        e = sb.pop_front();
        checks++;
        if (ok !== 1'b1 || rd !== e.rdata || er !== e.err || lat != 1) begin
            errors++;
            $display("FAIL read_addr3: ok=%b rdata=%h err=%b lat=%0d, required 1 %h %b 1", ok, rd, er, lat, e.rdata, e.err);
        end
        $display("txn read addr=3 rdata=%h err=%b", rd, er);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_handshake: valid=%b rdata=%h ready=%b, required 0 00000000 1", rsp_valid, rsp_rdata, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic        we_t[6];
        logic [31:0] a_t[6];
        logic [31:0] d_t[6];
        int          prev;
        bit          acc;
        exp_t        e;
        we_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        a_t  = '{32'd0, 32'd1023, 32'd0, 32'd1023, 32'd0, 32'd1023};
        d_t  = '{32'hA5A50000, 32'h5A5A03FF, 32'h0, 32'h0, 32'h0, 32'h0};
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            sb.push_back(we_t[i] ? '{1'b0, 32'h0} : '{1'b0, (a_t[i] == 32'd0) ? 32'hA5A50000 : 32'h5A5A03FF});
            send(1'b1, we_t[i], a_t[i], d_t[i], 1'b0, acc);
            e = sb.pop_front();
            checks++;
            if (acc !== 1'b1 || z_rsp_valid !== 1'b1 || z_req_ready !== 1'b0 ||
                z_rsp_rdata !== e.rdata || z_rsp_err !== e.err) begin
                errors++;
                $display("FAIL b2b_%0d: acc=%b valid=%b ready=%b rdata=%h err=%b, required 1 1 0 %h %b",
                         i, acc, z_rsp_valid, z_req_ready, z_rsp_rdata, z_rsp_err, e.rdata, e.err);
            end
            if (i > 0) begin
                checks++;
                if (cyc - prev != 2) begin
                    errors++;
                    $display("FAIL b2b_period_%0d: cycles=%0d, required 2", i, cyc - prev);
                end
            end
            prev = cyc;
            $display("txn b2b we=%b addr=%0d rdata=%h", we_t[i], a_t[i], z_rsp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_out_of_range();
        bit ok; int lat; logic [31:0] rd; logic er; exp_t e;
        sb.push_back('{1'b1, 32'h0});
        txn1(1'b0, 32'h00000400, 32'h0, 1'b0, ok, lat, rd, er);
        e = sb.pop_front();
        checks++;
        if (ok !== 1'b1 || rd !== e.rdata || er !== e.err) begin
            errors++;
            $display("FAIL oor_read_400: ok=%b rdata=%h err=%b, required 1 %h %b", ok, rd, er, e.rdata, e.err);
        end
        $display("txn read addr=00000400 err=%b", er);
        sb.push_back('{1'b1, 32'h0});
        txn1(1'b1, 32'h80000003, 32'hAAAA5555, 1'b0, ok, lat, rd, er);
        e = sb.pop_front();
        checks++;
        if (ok !== 1'b1 || rd !== e.rdata || er !== e.err) begin
            errors++;
            $display("FAIL oor_write_80000003: ok=%b rdata=%h err=%b, required 1 %h %b", ok, rd, er, e.rdata, e.err);
        end
        $display("txn write addr=80000003 err=%b", er);
        sb.push_back('{1'b0, 32'h12345678});
        txn1(1'b0, 32'd3, 32'h0, 1'b0, ok, lat, rd, er);
        e = sb.pop_front();
        checks++;
        if (ok !== 1'b1 || rd !== e.rdata || er !== e.err) begin
            errors++;
            $display("FAIL oor_addr3_kept: ok=%b rdata=%h err=%b, required 1 %h %b", ok, rd, er, e.rdata, e.err);
        end
    endtask

    task automatic test_backpressure();
        bit acc, got, ok; int lat; logic [31:0] rd; logic er; exp_t e;
        sb.push_back('{1'b0, 32'h12345678});
        send(1'b0, 1'b0, 32'd3, 32'h0, 1'b0, acc);
        wait_rsp(1'b0, got, lat);
        e = sb.pop_front();
        checks++;
        if (acc !== 1'b1 || got !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
            errors++;
            $display("FAIL bp_first: acc=%b got=%b rdata=%h err=%b, required 1 1 %h %b", acc, got, rsp_rdata, rsp_err, e.rdata, e.err);
        end
        req_we = 1'b1; req_addr = 32'd9; req_wdata = 32'hCAFE0009; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: valid=%b rdata=%h err=%b ready=%b, required 1 %h %b 0",
                         i, rsp_valid, rsp_rdata, rsp_err, req_ready, e.rdata, e.err);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: valid=%b rdata=%h err=%b ready=%b, required 0 00000000 0 1",
                     rsp_valid, rsp_rdata, rsp_err, req_ready);
        end
        sb.push_back('{1'b0, 32'h0});
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_late_accept: ready=%b, required 0", req_ready);
        end
        wait_rsp(1'b0, got, lat);
        e = sb.pop_front();
        checks++;
        if (got !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
            errors++;
            $display("FAIL bp_write9: got=%b rdata=%h err=%b, required 1 %h %b", got, rsp_rdata, rsp_err, e.rdata, e.err);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        sb.push_back('{1'b0, 32'hCAFE0009});
        txn1(1'b0, 32'd9, 32'h0, 1'b0, ok, lat, rd, er);
        e = sb.pop_front();
        checks++;
        if (ok !== 1'b1 || rd !== e.rdata || er !== e.err) begin
            errors++;
            $display("FAIL bp_read9: ok=%b rdata=%h err=%b, required 1 %h %b", ok, rd, er, e.rdata, e.err);
        end
        $display("txn backpressure: addr9 rdata=%h", rd);
    endtask

`ifdef PROTON_MEM_PARITY_EN
    task automatic test_parity();
        bit ok; int lat; logic [31:0] rd; logic er; exp_t e;
        logic        we_t[4];
        logic        inj_t[4];
        exp_t        ex_t[4];
        we_t  = '{1'b1, 1'b0, 1'b1, 1'b0};
        inj_t = '{1'b1, 1'b0, 1'b0, 1'b0};
        ex_t  = '{'{1'b0, 32'h0}, '{1'b1, 32'h0}, '{1'b0, 32'h0}, '{1'b0, 32'h1}};
        for (int i = 0; i < 4; i++) begin
            sb.push_back(ex_t[i]);
            txn1(we_t[i], 32'd7, 32'h1, inj_t[i], ok, lat, rd, er);
            e = sb.pop_front();
            checks++;
            if (ok !== 1'b1 || rd !== e.rdata || er !== e.err) begin
                errors++;
                $display("FAIL parity_%0d: ok=%b rdata=%h err=%b, required 1 %h %b", i, ok, rd, er, e.rdata, e.err);
            end
            $display("txn parity we=%b inj=%b rdata=%h err=%b", we_t[i], inj_t[i], rd, er);
        end
    endtask
`endif

    initial begin
        errors = 0; checks = 0; cyc = 0;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_rsp_ready = 1'b1;
`ifdef PROTON_MEM_PARITY_EN
        par_inject = 1'b0; z_par_inject = 1'b0;
`endif
        repeat (2) @(negedge clk);
        test_reset_entry();
    end

    task automatic test_reset_entry();
        test_reset();
        test_write_read();
        test_back_to_back();
        test_out_of_range();
        test_backpressure();
`ifdef PROTON_MEM_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // The first check inside test_reset runs while RST_N is still low; release it afterwards.
    initial begin
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    end

endmodule
